wb_reg_file: RTL and testbench
==============================

Name: wb_reg_file

Overview:
- RISC-V integer register file: 32 x 32 bits, two read ports and one write port.
- Sits directly downstream of the writeback-select 4:1 mux. The mux output (ALU result / load data / PC+4 / immediate) drives wr_data here.
- Read ports feed decode/execute operand selection.
- Provides x0 hardwiring and write-to-read bypass, so a same-cycle writeback is visible to decode without an extra stall.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must equal 2**AW.
- AW, 5, register address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- reg_write  input  1  write enable from the writeback stage.
- rd_addr  input  AW  destination register index.
- wr_data  input  XLEN  writeback data (output of the writeback-select mux).
- rs1_addr  input  AW  source register 1 index.
- rs2_addr  input  AW  source register 2 index.
- rs1_data  output  XLEN  read data for rs1 (combinational).
- rs2_data  output  XLEN  read data for rs2 (combinational).
- wr_busy  output  1  registered flag: a nonzero-register write was committed last cycle (debug/perf hook).

Behaviour:
- Reset:
  - rst high clears all NREGS registers to 0 immediately, without waiting for clk.
  - wr_busy = 0.
  - rs1_data and rs2_data therefore read 0 while reset is held.
- Write:
  - On a clk rising edge with rst low, reg_write=1 and rd_addr!=0, regs[rd_addr] <= wr_data.
  - Latency: 1 edge.
  - Writes with rd_addr=0 are discarded; x0 always holds 0.
- wr_busy:
  - Set to 1 on the edge following a committed write (reg_write=1, rd_addr!=0).
  - Otherwise set to 0 on each edge.
- Read (combinational, per port, in priority order):
  - addr==0 -> 0.
  - Else if reg_write=1 and rd_addr==addr -> wr_data (write-first bypass).
  - Else -> regs[addr].
- Both read ports are independent. rs1_addr==rs2_addr returns identical data on both.
- Simultaneous write and read of the same register returns the new value in the same cycle, and the stored value after the edge. This is the required bypass; no read-old-value behaviour.
- Bypass never applies to x0, even with reg_write=1 and rd_addr=0 and nonzero wr_data.
- Reset asserted mid-write: reset wins, and the register stays 0. On deassertion, the first write takes effect on the next rising edge.
- No X propagation: an unknown wr_data is only stored when reg_write=1.
- Storage is an array of XLEN-bit registers. There is no read enable and no stall input; the upstream pipeline holds reg_write low during stalls or bubbles.

Test Plan:
- Reset: hold rst=1, then drive rs1_addr=5, rs2_addr=31 -> both outputs read 0x00000000. Pulse rst asynchronously mid-cycle after writes -> outputs drop to 0 before the next clk edge.
- Basic write/read: write x5=0xDEADBEEF, then x31=0x12345678. Next cycle rs1_addr=5, rs2_addr=31 -> 0xDEADBEEF, 0x12345678. wr_busy=1 the cycle after each write.
- x0 protection: reg_write=1, rd_addr=0, wr_data=0xFFFFFFFF, rs1_addr=0 -> rs1_data=0 same cycle and after the edge. wr_busy stays 0.
- Bypass: x7 holds 0x11111111. Drive reg_write=1, rd_addr=7, wr_data=0x22222222, rs1_addr=rs2_addr=7 -> both read 0x22222222 before the edge and 0x22222222 after the edge with reg_write=0.
- Write disabled: reg_write=0, rd_addr=9, wr_data=0xAAAA5555 -> x9 unchanged (0). No bypass on rs2_addr=9.
- Sweep: write regs[i]=i*0x01010101 for i=1..31, then read all pairs (i, 32-i) -> matching values. Reg 0 reads 0.

Source files
------------

// File: rtl/wb_reg_file.sv
// wb_reg_file: 32 x XLEN integer register file with two combinational read
// ports, one write port, x0 hardwired to zero and write-first bypass so a
// value being written back this cycle is already visible to decode.
module wb_reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_write,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            wr_busy
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_busy_q;
    logic            wr_busy_d;
    logic            wr_en;

    // A write commits only for a nonzero destination, so x0 never stores.
    assign wr_en     = reg_write && (rd_addr != '0);
    assign wr_busy_d = wr_en;

    // Register array: async clear, single write port.
    // NOTE: the array is reset in full because architectural state must read
    // zero under reset; this rules out a plain RAM macro, which is acceptable
    // at 32 entries of flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rd_addr] <= wr_data;
        end
    end

    // Debug/perf flag: high for the cycle after a committed write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_busy_q <= 1'b0;
        end else begin
            wr_busy_q <= wr_busy_d;
        end
    end

    assign wr_busy = wr_busy_q;

    // Read port 1: x0 first, then write-first bypass, then stored value.
    // NOTE: every path assigns rs1_data, so no latch is inferred.
    always_comb begin
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (reg_write && (rd_addr == rs1_addr)) begin
            rs1_data = wr_data;
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
    end

    // Read port 2: same priority as port 1, fully independent.
    always_comb begin
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (reg_write && (rd_addr == rs2_addr)) begin
            rs2_data = wr_data;
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
    end

endmodule

// File: tb/tb_wb_reg_file.sv
// tb_wb_reg_file: directed scenarios plus a randomized run against a plain
// array model of the architectural register file.
module tb_wb_reg_file;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wr_busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model [32];
    logic        busy_exp;

    wb_reg_file #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .reg_write (reg_write),
        .rd_addr   (rd_addr),
        .wr_data   (wr_data),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wr_busy   (wr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value from the architectural rules and current inputs.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (reg_write && rd_addr == a) return wr_data;
        return model[a];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        busy_exp = 1'b0;
    endfunction

    // Advance one rising edge and update the model with what should commit.
    task automatic tick();
        bit commit;
        commit = reg_write && (rd_addr != 5'd0) && !rst;
        @(posedge clk);
        #1;
        if (commit) model[rd_addr] = wr_data;
        busy_exp = commit;
    endtask

    task automatic idle();
        reg_write = 1'b0;
        rd_addr   = 5'd0;
        wr_data   = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        rs1_addr = 5'd5;
        rs2_addr = 5'd31;
        model_clear();
        repeat (2) @(posedge clk);
        #3;
        n_cmp++;
        if (rs1_data !== 32'h0) begin n_err++; $display("FAIL reset_rs1: got %h want %h", rs1_data, 32'h0); end
        n_cmp++;
        if (rs2_data !== 32'h0) begin n_err++; $display("FAIL reset_rs2: got %h want %h", rs2_data, 32'h0); end
        n_cmp++;
        if (wr_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", wr_busy); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        reg_write = 1'b1; rd_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        n_cmp++;
        if (wr_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_x5: got %b want 1", wr_busy); end
        reg_write = 1'b1; rd_addr = 5'd31; wr_data = 32'h12345678;
        tick();
        n_cmp++;
        if (wr_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_x31: got %b want 1", wr_busy); end
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd31;
        #1;
        n_cmp++;
        if (rs1_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_rs1: got %h want %h", rs1_data, 32'hDEADBEEF); end
        n_cmp++;
        if (rs2_data !== 32'h12345678) begin n_err++; $display("FAIL basic_rs2: got %h want %h", rs2_data, 32'h12345678); end
        tick();
        n_cmp++;
        if (wr_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_idle: got %b want 0", wr_busy); end
    endtask

    task automatic test_x0();
        reg_write = 1'b1; rd_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        n_cmp++;
        if (rs1_data !== 32'h0) begin n_err++; $display("FAIL x0_bypass: got %h want %h", rs1_data, 32'h0); end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs1_data !== 32'h0) begin n_err++; $display("FAIL x0_stored: got %h want %h", rs1_data, 32'h0); end
        n_cmp++;
        if (wr_busy !== 1'b0) begin n_err++; $display("FAIL x0_busy: got %b want 0", wr_busy); end
    endtask

    task automatic test_bypass();
        reg_write = 1'b1; rd_addr = 5'd7; wr_data = 32'h11111111;
        tick();
        reg_write = 1'b1; rd_addr = 5'd7; wr_data = 32'h22222222;
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        #1;
        n_cmp++;
        if (rs1_data !== 32'h22222222) begin n_err++; $display("FAIL bypass_rs1_pre: got %h want %h", rs1_data, 32'h22222222); end
        n_cmp++;
        if (rs2_data !== 32'h22222222) begin n_err++; $display("FAIL bypass_rs2_pre: got %h want %h", rs2_data, 32'h22222222); end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs1_data !== 32'h22222222) begin n_err++; $display("FAIL bypass_rs1_post: got %h want %h", rs1_data, 32'h22222222); end
        n_cmp++;
        if (rs2_data !== 32'h22222222) begin n_err++; $display("FAIL bypass_rs2_post: got %h want %h", rs2_data, 32'h22222222); end
    endtask

    task automatic test_write_disabled();
        reg_write = 1'b0; rd_addr = 5'd9; wr_data = 32'hAAAA5555;
        rs2_addr = 5'd9;
        #1;
        n_cmp++;
        if (rs2_data !== 32'h0) begin n_err++; $display("FAIL wdis_no_bypass: got %h want %h", rs2_data, 32'h0); end
        tick();
        #1;
        n_cmp++;
        if (rs2_data !== 32'h0) begin n_err++; $display("FAIL wdis_unchanged: got %h want %h", rs2_data, 32'h0); end
        n_cmp++;
        if (wr_busy !== 1'b0) begin n_err++; $display("FAIL wdis_busy: got %b want 0", wr_busy); end
    endtask

    task automatic test_sweep();
        for (int i = 1; i < 32; i++) begin
            reg_write = 1'b1; rd_addr = 5'(i); wr_data = i * 32'h01010101;
            tick();
        end
        idle();
        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(32 - i);
            #1;
            n_cmp++;
            if (rs1_data !== i * 32'h01010101) begin n_err++; $display("FAIL sweep_rs1[%0d]: got %h want %h", i, rs1_data, i * 32'h01010101); end
            n_cmp++;
            if (rs2_data !== (32 - i) * 32'h01010101) begin n_err++; $display("FAIL sweep_rs2[%0d]: got %h want %h", 32 - i, rs2_data, (32 - i) * 32'h01010101); end
        end
        rs1_addr = 5'd0;
        #1;
        n_cmp++;
        if (rs1_data !== 32'h0) begin n_err++; $display("FAIL sweep_x0: got %h want %h", rs1_data, 32'h0); end
    endtask

    task automatic test_async_reset();
        // Registers are populated by the sweep; assert reset between edges.
        idle();
        rs1_addr = 5'd12; rs2_addr = 5'd20;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        n_cmp++;
        if (rs1_data !== 32'h0) begin n_err++; $display("FAIL areset_rs1: got %h want %h", rs1_data, 32'h0); end
        n_cmp++;
        if (rs2_data !== 32'h0) begin n_err++; $display("FAIL areset_rs2: got %h want %h", rs2_data, 32'h0); end
        // A write attempted while reset is held must not land.
        reg_write = 1'b1; rd_addr = 5'd12; wr_data = 32'hCAFEF00D;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs1_data !== 32'h0) begin n_err++; $display("FAIL areset_write_blocked: got %h want %h", rs1_data, 32'h0); end
        n_cmp++;
        if (wr_busy !== 1'b0) begin n_err++; $display("FAIL areset_busy: got %b want 0", wr_busy); end
        @(negedge clk);
        rst = 1'b0;
        reg_write = 1'b1; rd_addr = 5'd12; wr_data = 32'hCAFEF00D;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs1_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL areset_first_write: got %h want %h", rs1_data, 32'hCAFEF00D); end
        n_cmp++;
        if (wr_busy !== 1'b1) begin n_err++; $display("FAIL areset_first_busy: got %b want 1", wr_busy); end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        for (int n = 0; n < 400; n++) begin
            reg_write = 1'($urandom_range(0, 1));
            rd_addr   = 5'($urandom_range(0, 31));
            wr_data   = $urandom;
            rs1_addr  = 5'($urandom_range(0, 31));
            rs2_addr  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) rs1_addr = rd_addr;
            if ($urandom_range(0, 3) == 0) rs2_addr = rd_addr;
            #1;
            e1 = exp_read(rs1_addr);
            e2 = exp_read(rs2_addr);
            n_cmp++;
            if (rs1_data !== e1) begin n_err++; $display("FAIL rand_rs1[%0d] addr %0d: got %h want %h", n, rs1_addr, rs1_data, e1); end
            n_cmp++;
            if (rs2_data !== e2) begin n_err++; $display("FAIL rand_rs2[%0d] addr %0d: got %h want %h", n, rs2_addr, rs2_data, e2); end
            tick();
            n_cmp++;
            if (wr_busy !== busy_exp) begin n_err++; $display("FAIL rand_busy[%0d]: got %b want %b", n, wr_busy, busy_exp); end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        test_reset();
        test_basic();
        test_x0();
        test_bypass();
        test_write_disabled();
        test_sweep();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
